pc_gen: RTL and testbench

Parametrised program-counter generator for the RISC-V CPU fetch stage, replacing the fixed-width +4 PC register. It holds the fetch address, advances it on an accepted fetch, and honours the per-stage stall vector. It applies branch/jump redirects and trap vectors, and holds a redirect that arrives during a stall until the stall releases. It drives the instruction-memory request and sits between the pipeline control unit and the instruction-fetch interface.

---
 rtl/pc_gen_pkg.sv | 15 +
 rtl/pc_pend_buf.sv | 38 +++
 rtl/pc_gen.sv | 107 ++++++++++
 tb/tb_pc_gen.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and defaults for the fetch-stage program-counter generator.
package pc_gen_pkg;

    localparam int unsigned PcStageBit    = 0;
    localparam int unsigned DefXlen       = 32;
    localparam logic [31:0] DefResetVec   = 32'h0000_0000;
    localparam int unsigned DefInc        = 4;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_BOOT = 2'd1,
        ST_RUN  = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_pend_buf.sv
// Holds one redirect target that arrived while fetch could not advance.
module pc_pend_buf #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            consume,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            valid,
    output logic [XLEN-1:0] target
);

    logic is_trap;

    // A trap always replaces the entry; a redirect may not displace a held trap.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            is_trap <= 1'b0;
            target  <= '0;
        end else if (consume) begin
            valid   <= 1'b0;
            is_trap <= 1'b0;
        end else if (trap_valid) begin
            valid   <= 1'b1;
            is_trap <= 1'b1;
            target  <= trap_target;
        end else if (redirect_valid && !(valid && is_trap)) begin
            valid   <= 1'b1;
            is_trap <= 1'b0;
            target  <= redirect_target;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: sequential fetch, stall hold, redirect/trap
// steering with a one-entry pending buffer for redirects seen during stalls.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned            XLEN      = DefXlen,
    parameter logic [XLEN-1:0]        RESET_VEC = XLEN'(DefResetVec),
    parameter int unsigned            STALL_W   = 6,
    parameter int unsigned            INC       = DefInc
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               trap_valid,
    input  logic [XLEN-1:0]    trap_vec,
    input  logic               req_ready,
    output logic [XLEN-1:0]    pc,
    output logic               ce,
    output logic               pend_valid,
    output logic               misalign
);

    localparam logic [XLEN-1:0] LowMask = XLEN'(INC - 1);
    localparam logic [XLEN-1:0] Step    = XLEN'(INC);

    pc_state_e       state_q;
    pc_state_e       state_d;
    logic            active;
    logic            adv;
    logic [XLEN-1:0] trap_al;
    logic [XLEN-1:0] redir_al;
    logic            trap_low;
    logic            redir_low;
    logic [XLEN-1:0] pend_target;
    logic [XLEN-1:0] next_pc;
    logic            unused_stall;

    assign unused_stall = ^stall;

    assign trap_al   = trap_vec & ~LowMask;
    assign redir_al  = redirect_pc & ~LowMask;
    assign trap_low  = |(trap_vec & LowMask);
    assign redir_low = |(redirect_pc & LowMask);

    always_comb begin
        state_d = state_q;
        ce      = 1'b0;
        active  = 1'b0;
        case (state_q)
            ST_RST:  state_d = ST_BOOT;
            ST_BOOT: begin
                state_d = ST_RUN;
                active  = 1'b1;
            end
            ST_RUN: begin
                ce     = 1'b1;
                active = 1'b1;
            end
            default: state_d = ST_RST;
        endcase
    end

    assign adv = ce & req_ready & ~stall[PcStageBit];

    always_comb begin
        next_pc = pc + Step;
        if (trap_valid) begin
            next_pc = trap_al;
        end else if (redirect_valid) begin
            next_pc = redir_al;
        end else if (pend_valid) begin
            next_pc = pend_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RST;
            pc       <= RESET_VEC;
            misalign <= 1'b0;
        end else begin
            state_q  <= state_d;
            if (adv) begin
                pc <= next_pc;
            end
            // Only the target that actually wins arbitration can flag misalignment.
            misalign <= active & (trap_valid ? trap_low : (redirect_valid & redir_low));
        end
    end

    pc_pend_buf #(
        .XLEN(XLEN)
    ) u_pend (
        .clk             (clk),
        .rst             (rst),
        .consume         (adv),
        .trap_valid      (trap_valid & active),
        .trap_target     (trap_al),
        .redirect_valid  (redirect_valid & active),
        .redirect_target (redir_al),
        .valid           (pend_valid),
        .target          (pend_target)
    );

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with hand-computed expectations.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic [31:0] trap_vec;
    logic        req_ready;
    logic [31:0] pc;
    logic        ce;
    logic        pend_valid;
    logic        misalign;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN      (32),
        .RESET_VEC (32'h0000_0000),
        .STALL_W   (6),
        .INC       (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_vec       (trap_vec),
        .req_ready      (req_ready),
        .pc             (pc),
        .ce             (ce),
        .pend_valid     (pend_valid),
        .misalign       (misalign)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        stall          = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        trap_valid     = 1'b0;
        trap_vec       = '0;
        req_ready      = 1'b1;

        // Reset and boot
        repeat (3) tick();
        check("rst_ce", 32'(ce), 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_pend", 32'(pend_valid), 32'd0);
        check("rst_mis", 32'(misalign), 32'd0);
        rst = 1'b0;
        tick(); check("boot_pc0", pc, 32'h0); check("boot_ce0", 32'(ce), 32'd0);
        tick(); check("boot_pc1", pc, 32'h0); check("boot_ce1", 32'(ce), 32'd1);
        tick(); check("seq_pc4", pc, 32'h4);
        tick(); check("seq_pc8", pc, 32'h8);
        tick(); check("seq_pc12", pc, 32'hC);
        tick(); check("seq_pc16", pc, 32'h10);

        // Stall hold
        stall = 6'b000001;
        for (int i = 0; i < 3; i++) begin
            tick(); check("stall_hold", pc, 32'h10);
        end
        stall = '0;
        tick(); check("stall_rel", pc, 32'h14);
        stall = 6'b001000;
        tick(); check("stall3_noeff", pc, 32'h18);
        stall = '0;
        tick(); check("seq_1c", pc, 32'h1C);
        tick(); check("seq_20", pc, 32'h20);

        // Redirect during stall
        stall = 6'b000001; redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick(); check("rs_pc_hold", pc, 32'h20); check("rs_pend1", 32'(pend_valid), 32'd1);
        redirect_valid = 1'b0;
        tick(); check("rs_pc_hold2", pc, 32'h20); check("rs_pend2", 32'(pend_valid), 32'd1);
        stall = '0;
        tick(); check("rs_target", pc, 32'h100); check("rs_pend_clr", 32'(pend_valid), 32'd0);
        tick(); check("rs_next", pc, 32'h104);

        // Trap beats redirect in the same cycle
        trap_valid = 1'b1; trap_vec = 32'h80; redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick(); check("trap_win", pc, 32'h80);
        trap_valid = 1'b0; redirect_valid = 1'b0;
        tick(); check("trap_seq", pc, 32'h84);

        // Pending trap is not displaced by a later redirect
        stall = 6'b000001; trap_valid = 1'b1; trap_vec = 32'h80;
        tick(); check("ptrap_pend", 32'(pend_valid), 32'd1);
        trap_valid = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick(); check("ptrap_hold", pc, 32'h84);
        redirect_valid = 1'b0; stall = '0;
        tick(); check("ptrap_target", pc, 32'h80);

        // Misaligned target
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick(); check("mis_pc", pc, 32'h100); check("mis_pulse", 32'(misalign), 32'd1);
        redirect_valid = 1'b0;
        tick(); check("mis_clear", 32'(misalign), 32'd0); check("mis_seq", pc, 32'h104);

        // Wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick(); check("wrap_top", pc, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        tick(); check("wrap_zero", pc, 32'h0);

        // Backpressure
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick(); check("bp_start", pc, 32'h40);
        redirect_valid = 1'b0; req_ready = 1'b0;
        tick(); check("bp_hold1", pc, 32'h40);
        tick(); check("bp_hold2", pc, 32'h40); check("bp_ce", 32'(ce), 32'd1);
        req_ready = 1'b1;
        tick(); check("bp_rel", pc, 32'h44);

        // Mid-operation reset discards pending entry
        stall = 6'b000001; redirect_valid = 1'b1; redirect_pc = 32'h500;
        tick(); check("mr_pend", 32'(pend_valid), 32'd1);
        redirect_valid = 1'b0; rst = 1'b1;
        tick(); check("mr_pc", pc, 32'h0); check("mr_pend_clr", 32'(pend_valid), 32'd0);
        check("mr_ce", 32'(ce), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
